clk_divider: RTL and testbench



---
 rtl/clk_divider.sv | 105 ++++++++++
 tb/tb_clk_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// Programmable clock divider / single-step pulse generator driving the core-under-debug clock.
// Optional build macro CLK_DIVIDER_DIVLATCH_EN latches the divider at period/pulse boundaries.
module clk_divider #(
    parameter int COUNTER_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    option,
    input  logic                    out_enable,
    input  logic [COUNTER_BITS-1:0] divider,
    input  logic                    pulse,
    output logic                    clk_o
);

    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

    logic [COUNTER_BITS-1:0] cnt_reg, cnt_next;
    logic                    clk_o_reg, clk_o_next;
    logic                    busy_reg, busy_next;
    logic                    pulse_q_reg;
    logic                    option_q_reg;
    logic [COUNTER_BITS-1:0] div_eff;

    logic mode_change;
    logic pulse_edge;
    logic at_limit;

    assign mode_change = (option != option_q_reg);
    assign pulse_edge  = pulse & ~pulse_q_reg;
    // >= rather than == so a divider lowered mid-count wraps instead of running to overflow
    assign at_limit    = (cnt_reg >= div_eff);

`ifdef CLK_DIVIDER_DIVLATCH_EN
    logic [COUNTER_BITS-1:0] div_eff_reg;
    logic                    div_load;

    // Reload only where the waveform is at a boundary, so reprogramming never shortens a half-period
    assign div_load = !out_enable || mode_change ||
                      (!option && at_limit) ||
                      (option && (!busy_reg || at_limit));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_eff_reg <= '0;
        end else if (div_load) begin
            div_eff_reg <= divider;
        end
    end

    assign div_eff = div_eff_reg;
`else
    assign div_eff = divider;
`endif

    always_comb begin
        cnt_next   = cnt_reg;
        clk_o_next = clk_o_reg;
        busy_next  = busy_reg;
        if (!out_enable || mode_change) begin
            cnt_next   = '0;
            clk_o_next = 1'b0;
            busy_next  = 1'b0;
        end else if (!option) begin
            busy_next = 1'b0;
            if (at_limit) begin
                cnt_next   = '0;
                clk_o_next = ~clk_o_reg;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end else if (busy_reg) begin
            // Edges arriving while a step is in flight (including its final cycle) are dropped
            if (at_limit) begin
                cnt_next   = '0;
                clk_o_next = 1'b0;
                busy_next  = 1'b0;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end else if (pulse_edge) begin
            cnt_next   = '0;
            clk_o_next = 1'b1;
            busy_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            clk_o_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            pulse_q_reg  <= 1'b0;
            option_q_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            clk_o_reg    <= clk_o_next;
            busy_reg     <= busy_next;
            pulse_q_reg  <= pulse;
            option_q_reg <= option;
        end
    end

    assign clk_o = clk_o_reg;

endmodule

// File: tb/tb_clk_divider.sv
// Randomized + directed bench for clk_divider against an edge-count based reference model.
// Honours CLK_DIVIDER_DIVLATCH_EN for the mid-period reprogramming case.
module tb_clk_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        option;
    logic        out_enable;
    logic [31:0] divider;
    logic        pulse;
    logic        clk_o;

    always #5 clk = ~clk;

    clk_divider #(.COUNTER_BITS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .option     (option),
        .out_enable (out_enable),
        .divider    (divider),
        .pulse      (pulse),
        .clk_o      (clk_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: output derived from edge counts since the last restart event
    longint n       = 0;
    longint m_seg   = 0;
    longint m_start = 0;
    longint m_d     = 0;
    bit     m_prev_pulse = 1'b0;
    bit     m_prev_opt   = 1'b0;
    bit     m_active     = 1'b0;
    logic   exp_clk      = 1'b0;

    task automatic model_step();
        bit     restart;
        bit     rise;
        longint j;
        if (reset) begin
            m_prev_pulse = 1'b0;
            m_prev_opt   = 1'b0;
            m_active     = 1'b0;
            m_seg        = n;
            exp_clk      = 1'b0;
            return;
        end
        restart      = !out_enable || (option != m_prev_opt);
        rise         = pulse && !m_prev_pulse;
        m_prev_pulse = pulse;
        m_prev_opt   = option;
        if (restart) begin
            m_seg    = n;
            m_active = 1'b0;
            exp_clk  = 1'b0;
        end else if (!option) begin
            j       = n - m_seg;
            exp_clk = ((j / (longint'(divider) + 1)) % 2) != 0;
        end else if (m_active) begin
            if (n <= m_start + m_d) begin
                exp_clk = 1'b1;
            end else begin
                exp_clk  = 1'b0;
                m_active = 1'b0;
            end
        end else if (rise) begin
            m_active = 1'b1;
            m_start  = n;
            m_d      = longint'(divider);
            exp_clk  = 1'b1;
        end else begin
            exp_clk = 1'b0;
        end
    endtask

    task automatic tick(input string tag, input bit use_model);
        @(posedge clk);
        #1;
        n++;
        model_step();
        if (use_model) check_val(tag, clk_o, exp_clk);
    endtask

    initial begin
        int     highs;
        int     first_rise;
        bit     prev;
        logic   lvl;
        int     first_wrap;
        int     len;

        reset = 1'b1; option = 1'b0; out_enable = 1'b1; divider = 32'd0; pulse = 1'b0;
        tick("reset", 1);
        tick("reset", 1);
        reset = 1'b0;

        // divide by 2
        for (int i = 0; i < 8; i++) tick("div0", 1);

        // half-period 4, first rise on 4th enabled edge
        out_enable = 1'b0; divider = 32'd3;
        tick("div3_dis", 1);
        out_enable = 1'b1;
        first_rise = -1; prev = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick("div3", 1);
            if (clk_o && !prev && first_rise < 0) first_rise = i;
            prev = clk_o;
        end
        check_val("div3_first_rise", 64'(first_rise), 64'd4);

        // held pulse -> single 3-cycle step
        option = 1'b1; divider = 32'd2;
        tick("step_mode", 1);
        pulse = 1'b1; highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick("step_held", 1);
            if (clk_o) highs++;
        end
        check_val("step_held_width", 64'(highs), 64'd3);
        pulse = 1'b0;
        tick("step_rel", 1);
        tick("step_rel", 1);

        // second edge during a step is ignored
        divider = 32'd5; highs = 0;
        for (int i = 0; i < 12; i++) begin
            pulse = (i == 0 || i >= 2);
            tick("step_retrig", 1);
            if (clk_o) highs++;
        end
        check_val("step_retrig_width", 64'(highs), 64'd6);
        pulse = 1'b0;
        tick("step_rel", 1);

        // disable while high forces low next edge, re-enable restarts
        option = 1'b0; divider = 32'd7;
        tick("div7_mode", 1);
        for (int i = 0; i < 12; i++) tick("div7", 1);
        check_val("div7_high_before_dis", 64'(clk_o), 64'd1);
        out_enable = 1'b0;
        tick("div7_dis", 1);
        check_val("div7_dis_low", 64'(clk_o), 64'd0);
        out_enable = 1'b1;
        for (int i = 0; i < 20; i++) tick("div7_reen", 1);

        // lower divider 7->1 with cnt=4
        out_enable = 1'b0; divider = 32'd7;
        tick("dchg_dis", 1);
        out_enable = 1'b1;
        for (int i = 1; i <= 4; i++) tick("dchg_pre", 1);
        divider = 32'd1;
`ifdef CLK_DIVIDER_DIVLATCH_EN
        first_wrap = 8;
`else
        first_wrap = 5;
`endif
        lvl = 1'b0;
        for (int i = 5; i <= 16; i++) begin
            tick("dchg", 0);
            if (i >= first_wrap && ((i - first_wrap) % 2) == 0) lvl = ~lvl;
            check_val($sformatf("dchg_e%0d", i), 64'(clk_o), 64'(lvl));
        end

        // all-ones divider: half-period far beyond this window
        out_enable = 1'b0; divider = 32'hFFFF_FFFF;
        tick("ones_dis", 1);
        out_enable = 1'b1;
        for (int i = 0; i < 40; i++) tick("ones", 1);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            out_enable = 1'b0;
            option     = 1'($urandom_range(0, 1));
            divider    = 32'($urandom_range(0, 6));
            pulse      = 1'($urandom_range(0, 1));
            tick("rnd_dis", 1);
            out_enable = 1'b1;
            len = int'($urandom_range(15, 50));
            for (int i = 0; i < len; i++) begin
                if (option && $urandom_range(0, 3) == 0) pulse = ~pulse;
                if ($urandom_range(0, 39) == 0) option = ~option;
                if ($urandom_range(0, 59) == 0) out_enable = 1'b0;
                else out_enable = 1'b1;
                tick($sformatf("rnd%0d_m%0d", s, option), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
